// File: rtl/neo_pixel_strand_controller_param.sv
// Byte-loaded pixel buffer serialised onto a WS2812-style one-wire line; first neo_data rise 1 cycle after send_it.
// Frame = N*TBIT bit cycles + RESET_CYCLES latch gap; load_color/send_it accepted only in IDLE, otherwise dropped.
module neo_pixel_strand_controller_param #(
  parameter int NUM_PIXELS   = 8,
  parameter int NUM_CHANNELS = 3,
  parameter int T0H          = 35,
  parameter int T1H          = 80,
  parameter int TBIT         = 125,
  parameter int RESET_CYCLES = 5000,
  localparam int PIW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           load_color,
  input  logic [PIW-1:0] pixel_index,
  input  logic [1:0]     color_index,
  input  logic [7:0]     color_level,
  input  logic           send_it,
  output logic           neo_data,
  output logic           ready_to_load,
  output logic           ready_to_send,
  output logic           begin_send,
  output logic           done_send,
  output logic           done_wait
);

  localparam int NBYTES = NUM_PIXELS * NUM_CHANNELS;
  localparam int NBITS  = NBYTES * 8;
  localparam int CW     = $clog2(TBIT);
  localparam int BW     = $clog2(NBITS + 1);
  localparam int WW     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [CW-1:0] C_LAST = CW'(TBIT - 1);
  localparam logic [CW-1:0] C_T0H  = CW'(T0H);
  localparam logic [CW-1:0] C_T1H  = CW'(T1H);
  localparam logic [BW-1:0] B_LAST = BW'(NBITS - 1);
  localparam logic [WW-1:0] W_LAST = WW'(RESET_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       r_state;
  logic [NBITS-1:0] r_frame;
  logic [NBITS-1:0] r_shift;
  logic [CW-1:0]    r_cyc;
  logic [BW-1:0]    r_bit;
  logic [WW-1:0]    r_wait;
  logic             r_neo;
  logic             r_begin;
  logic             r_done_send;
  logic             r_done_wait;

  logic             w_wr_en;
  logic [31:0]      w_wr_sel;
  logic [7:0]       w_level_rev;
  logic [NBITS-1:0] w_frame_n;
  logic [1:0]       w_state_n;
  logic [NBITS-1:0] w_shift_n;
  logic [CW-1:0]    w_cyc_n;
  logic [BW-1:0]    w_bit_n;
  logic [WW-1:0]    w_wait_n;
  logic             w_neo_n;

  // Byte j holds pixel j/NUM_CHANNELS, channel j%NUM_CHANNELS, stored bit-reversed so bit 0 leaves first.
  always_comb begin
    w_wr_en = (r_state == S_IDLE) && load_color &&
              (32'(pixel_index) < NUM_PIXELS) && (32'(color_index) < NUM_CHANNELS);
    w_wr_sel = 32'(pixel_index) * NUM_CHANNELS + 32'(color_index);
    w_level_rev = '0;
    for (int i = 0; i < 8; i++) w_level_rev[i] = color_level[7-i];
    w_frame_n = r_frame;
    for (int j = 0; j < NBYTES; j++) begin
      if (w_wr_en && (w_wr_sel == 32'(j))) w_frame_n[j*8 +: 8] = w_level_rev;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_cyc_n   = r_cyc;
    w_bit_n   = r_bit;
    w_wait_n  = r_wait;
    case (r_state)
      S_IDLE: begin
        if (send_it) begin
          w_state_n = S_SEND;
          w_cyc_n   = '0;
          w_bit_n   = '0;
          w_shift_n = w_frame_n;
        end
      end
      S_SEND: begin
        if (r_cyc == C_LAST) begin
          w_cyc_n   = '0;
          w_shift_n = r_shift >> 1;
          if (r_bit == B_LAST) begin
            w_state_n = S_WAIT;
            w_wait_n  = '0;
          end else begin
            w_bit_n = r_bit + 1'b1;
          end
        end else begin
          w_cyc_n = r_cyc + 1'b1;
        end
      end
      S_WAIT: begin
        if (r_wait == W_LAST) w_state_n = S_IDLE;
        else                  w_wait_n  = r_wait + 1'b1;
      end
      default: w_state_n = S_IDLE;
    endcase
    // Line level is computed from next-state so neo_data leaves a flop and cannot glitch.
    w_neo_n = (w_state_n == S_SEND) && (w_cyc_n < (w_shift_n[0] ? C_T1H : C_T0H));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_frame     <= '0;
      r_shift     <= '0;
      r_cyc       <= '0;
      r_bit       <= '0;
      r_wait      <= '0;
      r_neo       <= 1'b0;
      r_begin     <= 1'b0;
      r_done_send <= 1'b0;
      r_done_wait <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_frame     <= w_frame_n;
      r_shift     <= w_shift_n;
      r_cyc       <= w_cyc_n;
      r_bit       <= w_bit_n;
      r_wait      <= w_wait_n;
      r_neo       <= w_neo_n;
      r_begin     <= (r_state == S_IDLE) && (w_state_n == S_SEND);
      r_done_send <= (r_state == S_SEND) && (w_state_n == S_WAIT);
      r_done_wait <= (w_state_n == S_WAIT) && (w_wait_n == W_LAST);
    end
  end

  assign neo_data      = r_neo;
  assign begin_send    = r_begin;
  assign done_send     = r_done_send;
  assign done_wait     = r_done_wait;
  assign ready_to_load = (r_state == S_IDLE);
  assign ready_to_send = (r_state == S_IDLE);

endmodule

// File: doc/neo_pixel_strand_controller_param.md
Name: neo_pixel_strand_controller_param

Overview:
- Parametrised successor to the fixed-size NeoPixel strand controller.
- Holds a per-pixel colour buffer loaded one byte at a time.
- On request, serialises the whole buffer onto a single WS2812-style one-wire line using cycle-count bit timing, then holds the line low for the latch gap.
- Pixel count, channels per pixel (GRB or GRBW) and all bit timings are generics, so one block serves 8-pixel and larger strands at any clock rate.

Parameters:
- NUM_PIXELS, 8: pixels on the strand (≥1).
- NUM_CHANNELS, 3: colour bytes per pixel (3 = GRB, 4 = GRBW).
- T0H, 35: clock cycles neo_data is high for a 0 bit.
- T1H, 80: clock cycles neo_data is high for a 1 bit (T0H < T1H < TBIT).
- TBIT, 125: total clock cycles per bit.
- RESET_CYCLES, 5000: low cycles after the last bit (latch gap).

Ports:
- clock  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- load_color  in  1  write strobe for one colour byte.
- pixel_index  in  $clog2(NUM_PIXELS) (min 1)  pixel to write.
- color_index  in  2  channel within the pixel; 0 is transmitted first.
- color_level  in  8  byte value.
- send_it  in  1  start a strand transmission.
- neo_data  out  1  one-wire serial output.
- ready_to_load  out  1  high when load_color is accepted.
- ready_to_send  out  1  high when send_it is accepted.
- begin_send  out  1  one-cycle pulse at transmission start.
- done_send  out  1  one-cycle pulse after the last bit.
- done_wait  out  1  one-cycle pulse at end of latch gap.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; colour buffer cleared to 0x00.
  - neo_data=0, begin_send=0, done_send=0, done_wait=0.
  - ready_to_load=1 and ready_to_send=1 once reset releases.
  - Reset mid-SEND or mid-WAIT aborts immediately: no done pulses, neo_data forced 0.
- States IDLE, SEND, WAIT:
  - IDLE: ready_to_load=ready_to_send=1; neo_data=0.
  - load_color=1 in IDLE writes buffer[pixel_index][color_index] <= color_level at that edge.
  - Writes with pixel_index ≥ NUM_PIXELS or color_index ≥ NUM_CHANNELS are dropped silently.
  - load_color in SEND/WAIT is ignored, buffer unchanged.
  - send_it=1 in IDLE moves to SEND at that edge.
  - If load_color and send_it are both high in IDLE, the write commits at the same edge and the transmission uses the new byte.
  - send_it in SEND/WAIT is ignored (no queuing).
  - SEND: begin_send=1 for exactly the first SEND cycle; ready_to_load and ready_to_send are 0.
- Bit order:
  - pixel 0 first, then ascending pixel; within a pixel, channel 0 .. NUM_CHANNELS-1; within a byte, MSB first.
  - Total bits N = NUM_PIXELS*NUM_CHANNELS*8.
- Bit timing:
  - Bit k occupies TBIT consecutive cycles.
  - neo_data=1 for the first T1H (bit=1) or T0H (bit=0) cycles, then 0 for the remainder.
  - The first bit begins in the cycle begin_send is high.
  - No idle cycles between bits or between pixels.
  - Cycle counter width $clog2(TBIT); bit counter width $clog2(N+1).
- Leaving SEND:
  - After the final cycle of bit N-1, state moves to WAIT.
  - done_send=1 for the first WAIT cycle, i.e. exactly N*TBIT cycles after begin_send.
- WAIT:
  - neo_data=0 for RESET_CYCLES cycles.
  - done_wait=1 in the last WAIT cycle, then IDLE on the next edge.
  - Earliest new send_it is accepted the cycle after done_wait.
  - The buffer is retained across transmissions; only reset clears it.
- Latency:
  - send_it edge to first neo_data rise: 1 cycle.
  - Full frame: 1 + N*TBIT + RESET_CYCLES cycles from send_it to return to IDLE.

Test Plan:
- Reset: hold reset=0 mid-frame, then release → neo_data=0 immediately, all pulses 0, ready_to_load=ready_to_send=1; a following send of 2 pixels emits all-zero bits.
- Single-byte timing with NUM_PIXELS=2, NUM_CHANNELS=3, T0H=2, T1H=4, TBIT=6, RESET_CYCLES=10:
  - Stimulus: load pixel0/ch0=0xA5, all else 0, then send_it.
  - Required: first byte high-times 4,2,4,2,2,4,2,4; remaining 40 bits 2-high/4-low; done_send exactly 288 cycles after begin_send; done_wait 10 cycles later.
- Ordering in RGBW mode (NUM_CHANNELS=4): load ch0=0x80, ch3=0x01 on pixel 1 → bit 32 is 1, bit 63 is 1, all others 0.
- Boundary write: pixel_index=NUM_PIXELS, or color_index=3 with NUM_CHANNELS=3 → buffer unchanged; next frame all zero.
- Busy handling: load_color 0xFF and send_it pulsed during SEND and WAIT → no buffer change, no restart; frame length unchanged.
- Simultaneous load_color(p0,c0,0xFF) and send_it in IDLE → first 8 bits are all 1s; then send again after done_wait → identical frame (buffer retained).
